bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter for multi-digit BCD values such as the cascaded outputs of our BCD counters. It accepts a packed DIGITS-wide BCD word over a valid/ready handshake and folds it most-significant digit first, using acc = acc*10 + digit, one digit per clock. It presents the binary result over a second valid/ready handshake. It sits between the decimal counting/display domain and binary datapath logic (comparators, timers, bus registers).

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_to_bin_if.sv | 32 +++
 rtl/bcd_mac10.sv | 20 ++
 rtl/bcd_to_bin.sv | 94 +++++++++
 tb/tb_bcd_to_bin.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Smallest result width able to hold 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for bcd_to_bin: BCD word in, binary result out.
// out_err exists only when BCD2BIN_CHECK_EN is defined.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
`ifdef BCD2BIN_CHECK_EN
  logic                  out_err;
`endif

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin
`ifdef BCD2BIN_CHECK_EN
    , input out_err
`endif
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin
`ifdef BCD2BIN_CHECK_EN
    , output out_err
`endif
  );
endinterface

// File: rtl/bcd_mac10.sv
// One fold step: acc*10 + digit via shift-add, truncated to BIN_W.
// With BCD2BIN_CHECK_EN a flag reports a non-decimal digit.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  bcd_digit_t       digit,
`ifdef BCD2BIN_CHECK_EN
  output logic             bad,
`endif
  output logic [BIN_W-1:0] acc_nxt
);
  // Nibbles 10..15 go into the sum unchanged.
  assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(digit);
`ifdef BCD2BIN_CHECK_EN
  assign bad = (digit > BCD_MAX);
`endif
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, MS digit first, one digit per clock.
// Optional digit check: BCD2BIN_CHECK_EN (adds out_err).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input logic         clk,
  input logic         rst,
  bcd_to_bin_if.slave bus
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (BIN_W < min_bin_w(DIGITS)) begin : g_width_chk
    $error("bcd_to_bin: BIN_W too small for DIGITS");
  end

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  sr_q;
  logic [CW-1:0]        cnt_q;
  logic [BIN_W-1:0]     acc_q, acc_nxt;
  logic                 accept;
  bcd_digit_t           digit;

  assign digit  = sr_q[4*DIGITS-1 -: 4];
  assign accept = (state_q == IDLE) && bus.in_valid;

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bin   = acc_q;

`ifdef BCD2BIN_CHECK_EN
  logic bad, err_q;

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc     (acc_q),
    .digit   (digit),
    .bad     (bad),
    .acc_nxt (acc_nxt)
  );

  // Sticky illegal-digit flag, cleared when a new word is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_q <= 1'b0;
    else if (accept)                       err_q <= 1'b0;
    else if (state_q == CONV && bad)       err_q <= 1'b1;
  end

  assign bus.out_err = err_q;
`else
  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc     (acc_q),
    .digit   (digit),
    .acc_nxt (acc_nxt)
  );
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept -> fold DIGITS steps -> hold until popped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = CONV;
      CONV:    if (cnt_q == '0)     state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Datapath: capture the word, then shift digits out MS first into acc.
  // acc is left untouched in DONE so the result holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      sr_q  <= bus.in_bcd;
      cnt_q <= CW'(DIGITS - 1);
      acc_q <= '0;
    end else if (state_q == CONV) begin
      sr_q  <= sr_q << 4;
      acc_q <= acc_nxt;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: 4-digit and 2-digit instances.
module tb_bcd_to_bin;
  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin_if #(.DIGITS(4), .BIN_W(14)) b4();
  bcd_to_bin_if #(.DIGITS(2), .BIN_W(7))  b2();

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  bcd_to_bin #(.DIGITS(2), .BIN_W(7))  u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

  // Offer a word on the 4-digit port; returns the acceptance cycle.
  task automatic send4(input logic [15:0] v, output int ecyc);
    int n;
    n = 0;
    b4.in_valid = 1'b1;
    b4.in_bcd   = v;
    while (!b4.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send4_timeout: in_ready stuck low, got %0b want 1", b4.in_ready);
    end
    @(posedge clk); #1;
    ecyc        = cyc;
    b4.in_valid = 1'b0;
    b4.in_bcd   = 16'hFFFF;  // later changes must not matter
  endtask

  task automatic wait_out4(output int ocyc);
    int n;
    n = 0;
    while (!b4.out_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (n >= 30) begin
      tests++; fails++;
      $display("FAIL wait_out4_timeout: out_valid got 0 want 1");
    end
    ocyc = cyc;
  endtask

  task automatic pop4();
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.in_valid = 0; b4.in_bcd = '0; b4.out_ready = 0;
    b2.in_valid = 0; b2.in_bcd = '0; b2.out_ready = 0;
    @(posedge clk); #1;
    tests++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.out_bin !== 14'd0) begin
      fails++;
      $display("FAIL reset4: rdy=%0b vld=%0b bin=%0d want 1 0 0", b4.in_ready, b4.out_valid, b4.out_bin);
    end
    tests++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0 || b2.out_bin !== 7'd0) begin
      fails++;
      $display("FAIL reset2: rdy=%0b vld=%0b bin=%0d want 1 0 0", b2.in_ready, b2.out_valid, b2.out_bin);
    end
`ifdef BCD2BIN_CHECK_EN
    tests++;
    if (b4.out_err !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %0b want 0", b4.out_err);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] vin [2];
    int          vexp[2];
    int e, o;
    vin[0] = 16'h0000; vexp[0] = 0;
    vin[1] = 16'h9999; vexp[1] = 9999;
    for (int i = 0; i < 2; i++) begin
      send4(vin[i], e);
      wait_out4(o);
      tests++;
      if (o - e !== 4) begin
        fails++; $display("FAIL basic_latency[%0d]: got %0d want 4", i, o - e);
      end
      tests++;
      if (b4.out_bin !== 14'(vexp[i])) begin
        fails++; $display("FAIL basic_bin[%0d]: got %0d want %0d", i, b4.out_bin, vexp[i]);
      end
      pop4();
    end
  endtask

  task automatic test_backpressure();
    int e, o;
    logic ok;
    send4(16'h1234, e);
    wait_out4(o);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (b4.out_bin !== 14'h04D2 || b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0) begin
        ok = 1'b0;
        $display("FAIL hold[%0d]: bin=%0h vld=%0b rdy=%0b want 4d2 1 0", k, b4.out_bin, b4.out_valid, b4.in_ready);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (!ok) fails++;
    pop4();
    tests++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin
      fails++; $display("FAIL after_pop: rdy=%0b vld=%0b want 1 0", b4.in_ready, b4.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int          acc_c[2];
    logic [13:0] res[2];
    int          na, np;
    logic        a, p;
    logic [13:0] r;
    na = 0; np = 0;
    acc_c[0] = 0; acc_c[1] = 0; res[0] = '0; res[1] = '0;
    b4.out_ready = 1'b1;
    b4.in_valid  = 1'b1;
    b4.in_bcd    = 16'h0001;
    for (int k = 0; k < 30 && np < 2; k++) begin
      a = b4.in_valid && b4.in_ready;
      p = b4.out_valid && b4.out_ready;
      r = b4.out_bin;
      @(posedge clk); #1;
      if (a && na < 2) begin
        acc_c[na] = cyc; na++;
        if (na == 1) b4.in_bcd = 16'h0010;
        else begin b4.in_valid = 1'b0; b4.in_bcd = '0; end
      end
      if (p && np < 2) begin res[np] = r; np++; end
    end
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b0;
    tests++;
    if (na !== 2 || np !== 2) begin
      fails++; $display("FAIL b2b_count: accepts=%0d pops=%0d want 2 2", na, np);
    end
    tests++;
    if (acc_c[1] - acc_c[0] !== 6) begin
      fails++; $display("FAIL b2b_spacing: got %0d want 6", acc_c[1] - acc_c[0]);
    end
    tests++;
    if (res[0] !== 14'd1 || res[1] !== 14'd10) begin
      fails++; $display("FAIL b2b_results: got %0d %0d want 1 10", res[0], res[1]);
    end
  endtask

  task automatic test_illegal();
    int e, o;
    send4(16'h12A4, e);
    wait_out4(o);
    tests++;
    if (b4.out_bin !== 14'd1304) begin
      fails++; $display("FAIL illegal_bin: got %0d want 1304", b4.out_bin);
    end
`ifdef BCD2BIN_CHECK_EN
    tests++;
    if (b4.out_err !== 1'b1) begin
      fails++; $display("FAIL illegal_err: got %0b want 1", b4.out_err);
    end
`endif
    pop4();
    send4(16'h0007, e);
    wait_out4(o);
    tests++;
    if (b4.out_bin !== 14'd7) begin
      fails++; $display("FAIL legal_bin: got %0d want 7", b4.out_bin);
    end
`ifdef BCD2BIN_CHECK_EN
    tests++;
    if (b4.out_err !== 1'b0) begin
      fails++; $display("FAIL legal_err: got %0b want 0", b4.out_err);
    end
`endif
    pop4();
    send4(16'hFFFF, e);
    wait_out4(o);
    tests++;
    if (b4.out_bin !== 14'd281) begin
      fails++; $display("FAIL wrap_bin: got %0d want 281", b4.out_bin);
    end
    pop4();
  endtask

  task automatic test_rst_abort();
    int e, o;
    logic ok;
    send4(16'h5678, e);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    tests++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin
      fails++; $display("FAIL abort_async: rdy=%0b vld=%0b want 1 0", b4.in_ready, b4.out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
        ok = 1'b0;
        $display("FAIL abort_stale[%0d]: vld=%0b rdy=%0b want 0 1", k, b4.out_valid, b4.in_ready);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (!ok) fails++;
    send4(16'h0042, e);
    wait_out4(o);
    tests++;
    if (b4.out_bin !== 14'd42 || o - e !== 4) begin
      fails++; $display("FAIL abort_next: bin=%0d lat=%0d want 42 4", b4.out_bin, o - e);
    end
    pop4();
  endtask

  task automatic test_two_digit();
    int e, n;
    b2.in_valid = 1'b1;
    b2.in_bcd   = 8'h99;
    @(posedge clk); #1;
    e = cyc;
    b2.in_valid = 1'b0;
    b2.in_bcd   = 8'h00;
    n = 0;
    while (!b2.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (cyc - e !== 2) begin
      fails++; $display("FAIL two_latency: got %0d want 2", cyc - e);
    end
    tests++;
    if (b2.out_bin !== 7'd99) begin
      fails++; $display("FAIL two_bin: got %0d want 99", b2.out_bin);
    end
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
    tests++;
    if (b2.in_ready !== 1'b1) begin
      fails++; $display("FAIL two_pop: rdy=%0b want 1", b2.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_rst_abort();
    test_two_digit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
